change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vending_pkg.sv | 31 +++
 rtl/coin_select.sv | 23 ++
 rtl/change_dispenser.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared constants and types for the change dispenser: coin values, amount width,
// FSM state encoding and the one-hot coin select bundle.
package vending_pkg;

  localparam int AMT_W = 5;

  localparam logic [AMT_W-1:0] COIN5  = AMT_W'(5);
  localparam logic [AMT_W-1:0] COIN10 = AMT_W'(10);
  localparam logic [AMT_W-1:0] COIN20 = AMT_W'(20);

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    DONE,
    FAULT
  } state_t;

  typedef struct packed {
    logic c20;
    logic c10;
    logic c5;
  } coin_sel_t;

  function automatic logic [AMT_W-1:0] coin_value(input coin_sel_t sel);
    if (sel.c20) return COIN20;
    if (sel.c10) return COIN10;
    if (sel.c5)  return COIN5;
    return '0;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest denomination that fits the amount owed and is in stock.
module coin_select
  import vending_pkg::*;
(
  input  logic [AMT_W-1:0] remaining_i,
  input  logic             has20_i,
  input  logic             has10_i,
  input  logic             has5_i,
  output coin_sel_t        sel_o,
  output logic             none_o
);

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_o = '0;
    if (remaining_i >= COIN20 && has20_i)      sel_o.c20 = 1'b1;
    else if (remaining_i >= COIN10 && has10_i) sel_o.c10 = 1'b1;
    else if (remaining_i >= COIN5 && has5_i)   sel_o.c5  = 1'b1;
  end

  assign none_o = !(sel_o.c20 || sel_o.c10 || sel_o.c5);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a loaded amount in 20/10/5 coins through a ready-handshaked
// hopper, tracking per-denomination stock and parking in FAULT until a refill.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AMT_W-1:0] change,
  input  logic             change_valid,
  input  logic             hopper_ready,
  input  logic             refill,
  output logic             coin20,
  output logic             coin10,
  output logic             coin5,
  output logic             busy,
  output logic             done,
  output logic             err_amt,
  output logic             fault,
  output logic [AMT_W-1:0] short_amt
);

  localparam logic [STOCK_W-1:0] STOCK_MAX  = '1;
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic [STOCK_W-1:0] stock20_q, stock20_d, stock10_q, stock10_d, stock5_q, stock5_d;
  coin_sel_t          coin_q, coin_d, pick;
  logic               err_q, err_d;
  logic               none, coin_up, handshake;

  assign coin_up   = coin_q.c20 || coin_q.c10 || coin_q.c5;
  assign handshake = coin_up && hopper_ready;

  // Refill overrides a coincident handshake; the guards keep a stock from wrapping.
  always_comb begin
    stock20_d = stock20_q;
    stock10_d = stock10_q;
    stock5_d  = stock5_q;
    if (refill) begin
      stock20_d = STOCK_MAX;
      stock10_d = STOCK_MAX;
      stock5_d  = STOCK_MAX;
    end else if (handshake) begin
      if (coin_q.c20 && stock20_q != '0) stock20_d = stock20_q - STOCK_ONE;
      if (coin_q.c10 && stock10_q != '0) stock10_d = stock10_q - STOCK_ONE;
      if (coin_q.c5 && stock5_q != '0)   stock5_d  = stock5_q - STOCK_ONE;
    end
  end

  always_comb begin
    remaining_d = remaining_q;
    if (state_q == IDLE && change_valid && change != '0 && (change % COIN5) == '0)
      remaining_d = change;
    else if (state_q == DISPENSE && handshake)
      remaining_d = remaining_q - coin_value(coin_q);
  end

  // Picking from next-cycle amount and stock lets the coin register present the
  // following coin straight after a handshake.
  coin_select u_coin_select (
    .remaining_i (remaining_d),
    .has20_i     (stock20_d != '0),
    .has10_i     (stock10_d != '0),
    .has5_i      (stock5_d != '0),
    .sel_o       (pick),
    .none_o      (none)
  );

  always_comb begin
    state_d = state_q;
    coin_d  = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (change_valid) begin
          if (change == '0) begin
            state_d = DONE;
          end else if ((change % COIN5) != '0) begin
            err_d = 1'b1;
          end else begin
            state_d = DISPENSE;
            coin_d  = pick;
          end
        end
      end
      DISPENSE: begin
        if (handshake || !coin_up) begin
          if (remaining_d == '0) state_d = DONE;
          else if (none)         state_d = FAULT;
          else                   coin_d  = pick;
        end else begin
          coin_d = coin_q;
        end
      end
      DONE: state_d = IDLE;
      FAULT: begin
        if (refill) begin
          state_d = DISPENSE;
          coin_d  = pick;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      stock20_q   <= STOCK_INIT;
      stock10_q   <= STOCK_INIT;
      stock5_q    <= STOCK_INIT;
      coin_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      stock20_q   <= stock20_d;
      stock10_q   <= stock10_d;
      stock5_q    <= stock5_d;
      coin_q      <= coin_d;
      err_q       <= err_d;
    end
  end

  assign coin20    = coin_q.c20;
  assign coin10    = coin_q.c10;
  assign coin5     = coin_q.c5;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err_amt   = err_q;
  assign fault     = (state_q == FAULT);
  assign short_amt = fault ? remaining_q : '0;

endmodule
